// File: rtl/game_pkg.sv
// Shared types and widths for the score keeper: game state encoding and
// the widths of the score and lives buses feeding the 7-segment driver.
package game_pkg;

  localparam int SCORE_W = 8;
  localparam int LIVES_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PLAY      = 2'b01,
    GAME_OVER = 2'b10
  } state_e;

endpackage

// File: rtl/button_debouncer.sv
// Synchronises a raw bouncy push-button into the clock domain, debounces it,
// and emits a one-cycle pulse on each debounced press (release is silent).
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             rise_q;
  logic [CNT_W-1:0] cnt_q;

  // The count only advances while the synchronised input disagrees with the
  // accepted level; any agreement (a bounce back) restarts it from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= sync2_q;
          rise_q  <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;

endmodule

// File: rtl/game_score_keeper.sv
// Owns game score and lives for the display driver and runs the
// IDLE / PLAY / GAME_OVER flow driven by hit/miss pulses and the start button.
module game_score_keeper
  import game_pkg::*;
#(
  parameter int START_LIVES     = 3,
  parameter int MAX_SCORE       = 99,
  parameter int HIT_POINTS      = 1,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               hit,
  input  logic               miss,
  output logic [SCORE_W-1:0] displayNumber,
  output logic [LIVES_W-1:0] lives,
  output logic               playing,
  output logic               game_over
);

  if (START_LIVES < 1 || START_LIVES > 9) begin : g_bad_start_lives
    $error("START_LIVES must be 1..9");
  end
  if (MAX_SCORE < 1 || MAX_SCORE > 99) begin : g_bad_max_score
    $error("MAX_SCORE must be 1..99");
  end
  if (HIT_POINTS < 1 || HIT_POINTS > MAX_SCORE) begin : g_bad_hit_points
    $error("HIT_POINTS must be 1..MAX_SCORE");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic btn_level;
  logic btn_rise;
  logic start_pulse;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (start_btn),
    .btn_level(btn_level),
    .btn_rise (btn_rise)
  );

  assign start_pulse = btn_rise & btn_level;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               playing_q;
  logic               game_over_q;
  logic [SCORE_W-1:0] score_sum;

  // Both operands fit in 8 bits with room to spare (99 + 99), so the sum
  // never wraps before the saturation compare.
  assign score_sum = score_q + SCORE_W'(HIT_POINTS);

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    unique case (state_q)
      IDLE: begin
        if (start_pulse) begin
          state_d = PLAY;
          score_d = '0;
          lives_d = LIVES_W'(START_LIVES);
        end
      end
      PLAY: begin
        if (miss) begin
          if (lives_q <= LIVES_W'(1)) begin
            lives_d = '0;
            state_d = GAME_OVER;
          end else begin
            lives_d = lives_q - LIVES_W'(1);
          end
        end else if (hit) begin
          score_d = (score_sum > SCORE_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : score_sum;
        end
      end
      GAME_OVER: begin
        lives_d = '0;
        if (start_pulse) begin
          state_d = PLAY;
          score_d = '0;
          lives_d = LIVES_W'(START_LIVES);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags decode the next state so they line up with score/lives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      score_q     <= '0;
      lives_q     <= LIVES_W'(START_LIVES);
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      playing_q   <= (state_d == PLAY);
      game_over_q <= (state_d == GAME_OVER);
    end
  end

  assign displayNumber = score_q;
  assign lives         = lives_q;
  assign playing       = playing_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_game_score_keeper.sv
// Randomised and directed bench for game_score_keeper against a rule-level
// model of the debounce window and the game flow.
module tb_game_score_keeper;

  localparam int DB    = 4;
  localparam int LIVES0 = 3;
  localparam int MAXS  = 99;
  localparam int HITP  = 1;

  logic       clk;
  logic       rst;
  logic       start_btn;
  logic       hit;
  logic       miss;
  logic [7:0] displayNumber;
  logic [3:0] lives;
  logic       playing;
  logic       game_over;

  int vecCount = 0;
  int errCount = 0;

  // Reference model state: 0 = waiting, 1 = in play, 2 = game over.
  int mState;
  int mScore;
  int mLives;
  bit mLevel;
  bit mRisePend;
  bit rawQ[$];

  game_score_keeper #(
    .START_LIVES    (LIVES0),
    .MAX_SCORE      (MAXS),
    .HIT_POINTS     (HITP),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_btn    (start_btn),
    .hit          (hit),
    .miss         (miss),
    .displayNumber(displayNumber),
    .lives        (lives),
    .playing      (playing),
    .game_over    (game_over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value with the model's expectation.
  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advances the model by one clock edge. The button is accepted once the
  // synchronised samples (raw delayed by two edges) have disagreed with the
  // accepted level for DB edges in a row; the game reacts one edge later.
  task automatic modelStep(input bit r, input bit b, input bit h, input bit m);
    bit startNow;
    bit flip;
    int sum;
    if (r) begin
      mState = 0;
      mScore = 0;
      mLives = LIVES0;
      mLevel = 1'b0;
      mRisePend = 1'b0;
      rawQ = {};
      repeat (DB + 1) rawQ.push_front(1'b0);
    end else begin
      startNow = mRisePend;
      flip = 1'b1;
      for (int i = 1; i <= DB; i++) if (rawQ[i] == mLevel) flip = 1'b0;
      mRisePend = flip && !mLevel;
      if (flip) mLevel = !mLevel;
      rawQ.push_front(b);
      void'(rawQ.pop_back());
      case (mState)
        0: if (startNow) begin mState = 1; mScore = 0; mLives = LIVES0; end
        1: begin
          if (m) begin
            mLives = (mLives > 0) ? mLives - 1 : 0;
            if (mLives == 0) mState = 2;
          end else if (h) begin
            sum = mScore + HITP;
            mScore = (sum > MAXS) ? MAXS : sum;
          end
        end
        default: if (startNow) begin mState = 1; mScore = 0; mLives = LIVES0; end
      endcase
    end
  endtask

  task automatic applyStimulus(input bit r, input bit b, input bit h, input bit m);
    rst = r;
    start_btn = b;
    hit = h;
    miss = m;
    modelStep(r, b, h, m);
    @(posedge clk);
    #1;
    checkOutput("score", displayNumber, 8'(mScore));
    checkOutput("lives", {4'd0, lives}, 8'(mLives));
    checkOutput("playing", {7'd0, playing}, {7'd0, mState == 1});
    checkOutput("game_over", {7'd0, game_over}, {7'd0, mState == 2});
  endtask

  initial begin
    rst = 1'b1; start_btn = 1'b0; hit = 1'b0; miss = 1'b0;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);

    // Idle with events pulsing: nothing should move.
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, i % 2 == 0, i % 3 == 0);

    // Bouncy press, then held long enough to start the game.
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0);

    // Five hits, up to ten, then simultaneous hit and miss.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0);
    end
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0);

    // Climb to 98, then three more hits into saturation.
    for (int i = 0; i < 88; i++) applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);

    // Remaining lives lost, then hits and misses in game over are ignored.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, i % 2 == 1);

    // Restart from game over, hold the button through play, then reset mid-game.
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, i > 12, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);

    // Random play with a wandering, bouncy button and occasional resets.
    begin
      bit btn = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(99) < 8) btn = ~btn;
        applyStimulus($urandom_range(299) == 0,
                      btn,
                      $urandom_range(99) < 30,
                      $urandom_range(99) < 6);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
